mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lisp_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 58 +++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisp_pkg.sv
// Shared types for the evaluator/collector memory arbiter.
package lisp_pkg;

    typedef logic [11:0] address_t;
    typedef logic [15:0] word_t;

    typedef enum logic {
        OWNER_EVAL = 1'b0,
        OWNER_GC   = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals around mem_arbiter.
//
// Handshakes: a requester raises *_req with a stable command and holds it
// until its one-cycle *_done pulse (dropping req after grant does not abort).
// The arbiter presents mem_req for exactly one cycle with the command; the
// memory answers later with a one-cycle mem_ready carrying mem_rdata. There
// is no back-pressure on mem_req and at most one memory command is in flight.
interface mem_arbiter_if;
    import lisp_pkg::*;

    logic     eval_req;
    logic     eval_we;
    address_t eval_addr;
    word_t    eval_wdata;
    logic     eval_done;
    word_t    eval_rdata;

    logic     gc_req;
    logic     gc_we;
    address_t gc_addr;
    word_t    gc_wdata;
    logic     gc_done;
    word_t    gc_rdata;

    logic     mem_req;
    logic     mem_we;
    address_t mem_addr;
    word_t    mem_wdata;
    logic     mem_ready;
    word_t    mem_rdata;

    logic     busy;
    logic     owner;
    logic     timeout;

    // Arbiter side.
    modport slave (
        input  eval_req, eval_we, eval_addr, eval_wdata,
        output eval_done, eval_rdata,
        input  gc_req, gc_we, gc_addr, gc_wdata,
        output gc_done, gc_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        output busy, owner, timeout
    );

    // Environment side: requesters plus memory.
    modport master (
        output eval_req, eval_we, eval_addr, eval_wdata,
        input  eval_done, eval_rdata,
        output gc_req, gc_we, gc_addr, gc_wdata,
        input  gc_done, gc_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        input  busy, owner, timeout
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (evaluator / collector) arbiter in front of a single memory with
// a one-outstanding-command protocol, round-robin tie break and a watchdog
// that aborts a WAIT that lasts TIMEOUT_CYCLES cycles. All outputs are
// registered.
module mem_arbiter
    import lisp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output arb_state_t   o_state
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    owner_t           r_last_owner;
    owner_t           r_owner;
    logic             r_we;
    address_t         r_addr;
    word_t            r_wdata;
    logic             r_mem_req;
    logic             r_busy;
    logic             r_timeout;
    logic             r_eval_done;
    logic             r_gc_done;
    word_t            r_eval_rdata;
    word_t            r_gc_rdata;

    logic             w_eval_ok;
    logic             w_gc_ok;
    logic             w_grant;
    logic             w_pick_gc;

    // Eligibility and tie break: a port whose done is high this cycle is not
    // eligible, so a held req is not served twice back to back.
    always_comb begin
        w_eval_ok = bus.eval_req && !r_eval_done;
        w_gc_ok   = bus.gc_req && !r_gc_done;
        w_grant   = w_eval_ok || w_gc_ok;
        w_pick_gc = w_gc_ok && (!w_eval_ok || (r_last_owner == OWNER_EVAL));
    end

    // Control FSM, watchdog, latched command and per-port read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_owner <= OWNER_GC;
            r_owner      <= OWNER_EVAL;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_req    <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_eval_done  <= 1'b0;
            r_gc_done    <= 1'b0;
            r_eval_rdata <= '0;
            r_gc_rdata   <= '0;
        end else begin
            r_mem_req   <= 1'b0;
            r_timeout   <= 1'b0;
            r_eval_done <= 1'b0;
            r_gc_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner   <= w_pick_gc ? OWNER_GC : OWNER_EVAL;
                        r_we      <= w_pick_gc ? bus.gc_we    : bus.eval_we;
                        r_addr    <= w_pick_gc ? bus.gc_addr  : bus.eval_addr;
                        r_wdata   <= w_pick_gc ? bus.gc_wdata : bus.eval_wdata;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_ready || (r_cnt == CNT_LAST)) begin
                        // A reply arriving on the last watchdog cycle still wins.
                        if (bus.mem_ready && !r_we) begin
                            if (r_owner == OWNER_GC) begin
                                r_gc_rdata <= bus.mem_rdata;
                            end else begin
                                r_eval_rdata <= bus.mem_rdata;
                            end
                        end
                        r_timeout    <= !bus.mem_ready;
                        r_eval_done  <= (r_owner == OWNER_EVAL);
                        r_gc_done    <= (r_owner == OWNER_GC);
                        r_last_owner <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.owner      = r_owner;
    assign bus.timeout    = r_timeout;
    assign bus.eval_done  = r_eval_done;
    assign bus.eval_rdata = r_eval_rdata;
    assign bus.gc_done    = r_gc_done;
    assign bus.gc_rdata   = r_gc_rdata;
    assign o_state        = arb_state_t'(r_state);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (grant rule, latency, watchdog, rdata).
module tb_mem_arbiter;
    import lisp_pkg::*;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    arb_state_t state;
    int         errors = 0;
    int         checks = 0;

    mem_arbiter_if bus_if();

    mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .o_state (state)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1);
    end

    // Driver tasks.
    task automatic idle_inputs();
        bus_if.eval_req   = 1'b0;
        bus_if.eval_we    = 1'b0;
        bus_if.eval_addr  = '0;
        bus_if.eval_wdata = '0;
        bus_if.gc_req     = 1'b0;
        bus_if.gc_we      = 1'b0;
        bus_if.gc_addr    = '0;
        bus_if.gc_wdata   = '0;
        bus_if.mem_ready  = 1'b0;
        bus_if.mem_rdata  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_eval(input logic we, input address_t a, input word_t d);
        bus_if.eval_req   = 1'b1;
        bus_if.eval_we    = we;
        bus_if.eval_addr  = a;
        bus_if.eval_wdata = d;
    endtask

    task automatic drive_gc(input logic we, input address_t a, input word_t d);
        bus_if.gc_req   = 1'b1;
        bus_if.gc_we    = we;
        bus_if.gc_addr  = a;
        bus_if.gc_wdata = d;
    endtask

    function automatic logic [66:0] all_outs();
        return {bus_if.mem_req, bus_if.mem_we, bus_if.busy, bus_if.owner,
                bus_if.timeout, bus_if.eval_done, bus_if.gc_done,
                bus_if.mem_addr, bus_if.mem_wdata, bus_if.eval_rdata, bus_if.gc_rdata};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        drive_eval(1'b1, 12'hFFF, 16'hFFFF);
        drive_gc(1'b1, 12'hFFF, 16'hFFFF);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'hFFFF;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (all_outs() !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        checks++;
        if (state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", state, IDLE);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_eval_read();
        do_reset();
        drive_eval(1'b0, 12'h004, 16'h9999);             // cycle 0
        @(negedge clk);                                    // cycle 1
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.busy, bus_if.owner}
            !== {1'b1, 1'b0, 12'h004, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL eval_read_issue got req=%b we=%b addr=%h busy=%b owner=%b exp 1 0 004 1 0",
                     bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.busy, bus_if.owner);
        end
        bus_if.mem_ready = 1'b1;                           // ignored in ISSUE
        bus_if.mem_rdata = 16'hDEAD;
        @(negedge clk);                                    // cycle 2
        checks++;
        if ({bus_if.mem_req, bus_if.eval_done} !== 2'b00) begin
            errors++;
            $display("FAIL eval_read_wait got req=%b done=%b exp 0 0", bus_if.mem_req, bus_if.eval_done);
        end
        bus_if.mem_rdata = 16'h1234;
        @(negedge clk);                                    // cycle 3
        checks++;
        if ({bus_if.eval_done, bus_if.eval_rdata, bus_if.gc_done, bus_if.timeout}
            !== {1'b1, 16'h1234, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL eval_read_done got done=%b rdata=%h gc_done=%b to=%b exp 1 1234 0 0",
                     bus_if.eval_done, bus_if.eval_rdata, bus_if.gc_done, bus_if.timeout);
        end
        bus_if.mem_ready = 1'b0;
        bus_if.eval_req  = 1'b0;
        @(negedge clk);                                    // cycle 4
        checks++;
        if ({bus_if.eval_done, bus_if.busy, bus_if.mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL eval_read_after got done=%b busy=%b req=%b exp 0 0 0",
                     bus_if.eval_done, bus_if.busy, bus_if.mem_req);
        end
    endtask

    task automatic test_gc_write();
        do_reset();
        drive_gc(1'b0, 12'h011, 16'h0000);                 // read to seed gc_rdata
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'h5A5A;
        @(negedge clk);
        bus_if.mem_ready = 1'b0;
        bus_if.gc_req    = 1'b0;
        checks++;
        if ({bus_if.gc_done, bus_if.gc_rdata} !== {1'b1, 16'h5A5A}) begin
            errors++;
            $display("FAIL gc_read_done got done=%b rdata=%h exp 1 5a5a", bus_if.gc_done, bus_if.gc_rdata);
        end
        @(negedge clk);
        drive_gc(1'b1, 12'h010, 16'hBEEF);                 // cycle 0
        @(negedge clk);                                    // cycle 1
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.owner}
            !== {1'b1, 1'b1, 12'h010, 16'hBEEF, 1'b1}) begin
            errors++;
            $display("FAIL gc_write_issue got req=%b we=%b addr=%h wdata=%h owner=%b exp 1 1 010 beef 1",
                     bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.owner);
        end
        @(negedge clk);                                    // cycle 2
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'hFFFF;
        @(negedge clk);                                    // cycle 3
        checks++;
        if ({bus_if.gc_done, bus_if.gc_rdata, bus_if.eval_done} !== {1'b1, 16'h5A5A, 1'b0}) begin
            errors++;
            $display("FAIL gc_write_done got done=%b rdata=%h eval_done=%b exp 1 5a5a 0",
                     bus_if.gc_done, bus_if.gc_rdata, bus_if.eval_done);
        end
        idle_inputs();
    endtask

    task automatic test_tie_alternation();
        int   n;
        logic ready_next;
        logic got;
        do_reset();
        drive_eval(1'b0, 12'h100, 16'h0);
        drive_gc(1'b0, 12'h201, 16'h0);
        n = 0;
        ready_next = 1'b0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            @(negedge clk);
            if (bus_if.eval_done && bus_if.gc_done) begin
                checks++;
                errors++;
                $display("FAIL tie_double_done got both done high at txn %0d", n);
            end else if (bus_if.eval_done || bus_if.gc_done) begin
                got = bus_if.gc_done;
                checks++;
                if (got !== 1'(n % 2)) begin
                    errors++;
                    $display("FAIL tie_order txn=%0d got owner=%b exp=%b", n, got, 1'(n % 2));
                end
                n++;
            end
            bus_if.mem_ready = ready_next;
            bus_if.mem_rdata = 16'(c);
            ready_next = bus_if.mem_req;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL tie_count got=%0d exp=8", n);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        drive_eval(1'b0, 12'h020, 16'h0);
        @(negedge clk);
        @(negedge clk);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'hCAFE;
        @(negedge clk);                                    // done of seeding read
        idle_inputs();
        @(negedge clk);
        drive_eval(1'b0, 12'h022, 16'h0);                  // cycle 0
        @(negedge clk);                                    // cycle 1
        for (int c = 2; c <= T + 1; c++) begin
            @(negedge clk);
            bus_if.mem_rdata = 16'h0BAD;
            checks++;
            if ({bus_if.eval_done, bus_if.timeout, bus_if.busy} !== 3'b001) begin
                errors++;
                $display("FAIL timeout_wait cycle=%0d got done=%b to=%b busy=%b exp 0 0 1",
                         c, bus_if.eval_done, bus_if.timeout, bus_if.busy);
            end
        end
        @(negedge clk);                                    // cycle T+2
        bus_if.eval_req = 1'b0;
        checks++;
        if ({bus_if.eval_done, bus_if.timeout, bus_if.eval_rdata, bus_if.gc_done, bus_if.busy}
            !== {1'b1, 1'b1, 16'hCAFE, 1'b0, 1'b0} || state !== IDLE) begin
            errors++;
            $display("FAIL timeout_abort got done=%b to=%b rdata=%h gc_done=%b busy=%b state=%0d exp 1 1 cafe 0 0 0",
                     bus_if.eval_done, bus_if.timeout, bus_if.eval_rdata, bus_if.gc_done, bus_if.busy, state);
        end
        @(negedge clk);
        checks++;
        if ({bus_if.eval_done, bus_if.timeout} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse got done=%b to=%b exp 0 0", bus_if.eval_done, bus_if.timeout);
        end
        drive_gc(1'b0, 12'h031, 16'h0);                    // cycle 0
        @(negedge clk);                                    // cycle 1
        @(negedge clk);                                    // cycle 2
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'h7777;
        @(negedge clk);                                    // cycle 3
        checks++;
        if ({bus_if.gc_done, bus_if.gc_rdata, bus_if.timeout} !== {1'b1, 16'h7777, 1'b0}) begin
            errors++;
            $display("FAIL timeout_recover got done=%b rdata=%h to=%b exp 1 7777 0",
                     bus_if.gc_done, bus_if.gc_rdata, bus_if.timeout);
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        drive_eval(1'b0, 12'h062, 16'h0);
        @(negedge clk);
        @(negedge clk);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'h1111;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        drive_eval(1'b0, 12'h060, 16'h0);                  // cycle 0
        @(negedge clk);                                    // cycle 1
        @(negedge clk);                                    // cycle 2 (WAIT)
        rst = 1'b1;
        bus_if.eval_req = 1'b0;
        @(negedge clk);                                    // cycle 3
        rst = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'hABCD;
        checks++;
        if (all_outs() !== 67'd0 || state !== IDLE) begin
            errors++;
            $display("FAIL rst_wait_outputs got=%h state=%0d exp 0 0", all_outs(), state);
        end
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            bus_if.mem_ready = 1'b0;
            checks++;
            if (all_outs() !== 67'd0) begin
                errors++;
                $display("FAIL rst_wait_late cycle=%0d got=%h exp=0", c, all_outs());
            end
        end
    endtask

    task automatic test_hold_req();
        do_reset();
        drive_eval(1'b0, 12'h040, 16'h0);                  // cycle 0
        @(negedge clk);                                    // cycle 1
        bus_if.eval_addr  = 12'h7FF;                       // must not disturb txn
        bus_if.eval_we    = 1'b1;
        bus_if.eval_wdata = 16'h4242;
        @(negedge clk);                                    // cycle 2
        checks++;
        if ({bus_if.mem_addr, bus_if.mem_we} !== {12'h040, 1'b0}) begin
            errors++;
            $display("FAIL hold_latched got addr=%h we=%b exp 040 0", bus_if.mem_addr, bus_if.mem_we);
        end
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'h4444;
        @(negedge clk);                                    // cycle 3, req still high
        bus_if.mem_ready = 1'b0;
        checks++;
        if ({bus_if.eval_done, bus_if.eval_rdata} !== {1'b1, 16'h4444}) begin
            errors++;
            $display("FAIL hold_done got done=%b rdata=%h exp 1 4444", bus_if.eval_done, bus_if.eval_rdata);
        end
        @(negedge clk);                                    // cycle 4
        checks++;
        if ({bus_if.mem_req, bus_if.busy} !== 2'b00) begin
            errors++;
            $display("FAIL hold_no_regrant got req=%b busy=%b exp 0 0", bus_if.mem_req, bus_if.busy);
        end
        @(negedge clk);                                    // cycle 5
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata}
            !== {1'b1, 1'b1, 12'h7FF, 16'h4242}) begin
            errors++;
            $display("FAIL hold_regrant got req=%b we=%b addr=%h wdata=%h exp 1 1 7ff 4242",
                     bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata);
        end
        @(negedge clk);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'h9999;
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({bus_if.eval_done, bus_if.eval_rdata} !== {1'b1, 16'h4444}) begin
            errors++;
            $display("FAIL hold_write_done got done=%b rdata=%h exp 1 4444", bus_if.eval_done, bus_if.eval_rdata);
        end
        @(negedge clk);
        drive_gc(1'b0, 12'h051, 16'h0);                    // cycle 0
        @(negedge clk);                                    // cycle 1
        bus_if.gc_req = 1'b0;                              // dropped mid-transaction
        @(negedge clk);                                    // cycle 2
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 16'h5151;
        @(negedge clk);                                    // cycle 3
        bus_if.mem_ready = 1'b0;
        checks++;
        if ({bus_if.gc_done, bus_if.gc_rdata, bus_if.eval_done} !== {1'b1, 16'h5151, 1'b0}) begin
            errors++;
            $display("FAIL drop_req_done got done=%b rdata=%h eval_done=%b exp 1 5151 0",
                     bus_if.gc_done, bus_if.gc_rdata, bus_if.eval_done);
        end
        idle_inputs();
    endtask

    // Randomized traffic. Model: one transaction at a time; grant goes to the
    // only eligible port, or to the port that did not finish last on a tie;
    // done arrives d+2 cycles after mem_req when memory answers after d WAIT
    // cycles (d < T), else T+1 cycles later with a timeout and old rdata.
    task automatic test_random();
        logic [17:0]  exp_q[$];                            // {port, timeout, rdata}
        int           exp_at_q[$];
        logic [17:0]  item;
        logic         act[2];
        logic         cwe[2];
        address_t     caddr[2];
        word_t        cwd[2];
        word_t        model_rd[2];
        logic         prev_req[2];
        logic         e_dn[2];
        logic         e_to;
        logic         last_owner;
        logic         prev_mem_req;
        logic         exp_p;
        word_t        got_rd;
        word_t        rd;
        word_t        data;
        word_t        ready_data;
        int unsigned  d;
        int           ready_at;
        int           done_at;
        logic         to;

        do_reset();
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0;
            model_rd[p] = '0;
            prev_req[p] = 1'b0;
            cwe[p] = 1'b0;
            caddr[p] = '0;
            cwd[p] = '0;
        end
        last_owner   = 1'b1;
        prev_mem_req = 1'b0;
        ready_at     = -1;
        ready_data   = '0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            e_dn[0] = 1'b0;
            e_dn[1] = 1'b0;
            e_to    = 1'b0;
            if (exp_q.size() > 0 && exp_at_q[0] == cyc) begin
                item = exp_q.pop_front();
                void'(exp_at_q.pop_front());
                e_dn[item[17]] = 1'b1;
                e_to = item[16];
                got_rd = item[17] ? bus_if.gc_rdata : bus_if.eval_rdata;
                checks++;
                if (got_rd !== item[15:0]) begin
                    errors++;
                    $display("FAIL rand_rdata cyc=%0d port=%b got=%h exp=%h", cyc, item[17], got_rd, item[15:0]);
                end
                last_owner = item[17];
                act[item[17]] = 1'b0;
            end
            checks++;
            if ({bus_if.eval_done, bus_if.gc_done, bus_if.timeout} !== {e_dn[0], e_dn[1], e_to}) begin
                errors++;
                $display("FAIL rand_done cyc=%0d got eval=%b gc=%b to=%b exp %b %b %b", cyc,
                         bus_if.eval_done, bus_if.gc_done, bus_if.timeout, e_dn[0], e_dn[1], e_to);
            end
            if (bus_if.mem_req) begin
                checks++;
                if (prev_mem_req || exp_q.size() > 0) begin
                    errors++;
                    $display("FAIL rand_overlap cyc=%0d got mem_req while busy exp none", cyc);
                end
                exp_p = (prev_req[0] && prev_req[1]) ? !last_owner : prev_req[1];
                checks++;
                if ({bus_if.owner, bus_if.busy, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata}
                    !== {exp_p, 1'b1, cwe[exp_p], caddr[exp_p], cwd[exp_p]}) begin
                    errors++;
                    $display("FAIL rand_grant cyc=%0d got owner=%b busy=%b we=%b addr=%h wd=%h exp %b 1 %b %h %h",
                             cyc, bus_if.owner, bus_if.busy, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata,
                             exp_p, cwe[exp_p], caddr[exp_p], cwd[exp_p]);
                end
                d = $urandom_range(0, T + 1);
                data = word_t'($urandom);
                if (d < T) begin
                    ready_at   = cyc + 1 + int'(d);
                    ready_data = data;
                    done_at    = cyc + 2 + int'(d);
                    rd         = cwe[exp_p] ? model_rd[exp_p] : data;
                    to         = 1'b0;
                end else begin
                    done_at = cyc + T + 1;
                    rd      = model_rd[exp_p];
                    to      = 1'b1;
                end
                model_rd[exp_p] = rd;
                exp_q.push_back({exp_p, to, rd});
                exp_at_q.push_back(done_at);
            end
            prev_mem_req = bus_if.mem_req;

            bus_if.mem_ready = (cyc == ready_at);
            bus_if.mem_rdata = (cyc == ready_at) ? ready_data : word_t'($urandom);
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && cyc < 3800 && $urandom_range(0, 3) == 0) begin
                    act[p]   = 1'b1;
                    cwe[p]   = 1'($urandom_range(0, 1));
                    caddr[p] = {11'($urandom), 1'(p)};
                    cwd[p]   = word_t'($urandom);
                end
                prev_req[p] = act[p] && !e_dn[p];
            end
            bus_if.eval_req   = act[0];
            bus_if.eval_we    = act[0] ? cwe[0]   : 1'($urandom);
            bus_if.eval_addr  = act[0] ? caddr[0] : address_t'($urandom);
            bus_if.eval_wdata = act[0] ? cwd[0]   : word_t'($urandom);
            bus_if.gc_req     = act[1];
            bus_if.gc_we      = act[1] ? cwe[1]   : 1'($urandom);
            bus_if.gc_addr    = act[1] ? caddr[1] : address_t'($urandom);
            bus_if.gc_wdata   = act[1] ? cwd[1]   : word_t'($urandom);
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || act[0] || act[1]) begin
            errors++;
            $display("FAIL rand_drain got pending=%0d act=%b%b exp 0 00", exp_q.size(), act[0], act[1]);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_eval_read();
        test_gc_write();
        test_tie_alternation();
        test_timeout();
        test_reset_in_wait();
        test_hold_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
